fetch_inst_queue: RTL and testbench

FETCH_INST_QUEUE -- requirements
Module: fetch_inst_queue

---
 rtl/fetch_inst_queue.sv | 80 ++++++++
 tb/tb_fetch_inst_queue.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_inst_queue.sv
// Fetch instruction queue: splits 64-bit fetch beats into 32-bit instructions; output is registered, 1-cycle push-to-out latency.
// in_ready depends only on registered occupancy and needs room for a full two-instruction beat; flush/reset discard everything.
module fetch_inst_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [63:0]              in_pc,
  input  logic [63:0]              in_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic [63:0]              out_pc,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // PCs are word aligned, so only bits [63:2] are stored.
  logic [31:0]   r_inst [DEPTH];
  logic [61:0]   r_pc   [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          w_push;
  logic          w_pop;
  logic          w_pair;
  logic [AW-1:0] w_hi_slot;
  logic [CW-1:0] w_npush;
  logic [1:0]    w_unused_pc_lsb;

  assign w_unused_pc_lsb = in_pc[1:0];

  assign in_ready  = !reset && !flush && ((CW'(DEPTH) - r_count) >= CW'(2));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // An aligned beat carries two instructions; an odd-word beat only its upper half.
  assign w_pair    = !in_pc[2];
  assign w_hi_slot = w_pair ? r_wptr + AW'(1) : r_wptr;
  assign w_npush   = w_push ? (w_pair ? CW'(2) : CW'(1)) : '0;

  always_ff @(posedge clk) begin
    if (w_push) begin
      if (w_pair) begin
        r_inst[r_wptr] <= in_data[31:0];
        r_pc[r_wptr]   <= {in_pc[63:3], 1'b0};
      end
      // Upper half always sits at word address {pc[63:3],1}; no carry possible.
      r_inst[w_hi_slot] <= in_data[63:32];
      r_pc[w_hi_slot]   <= {in_pc[63:3], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + w_npush[AW-1:0];
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= r_count + w_npush - (w_pop ? CW'(1) : CW'(0));
    end
  end

  assign out_inst = r_inst[r_rptr];
  assign out_pc   = {r_pc[r_rptr], 2'b00};
  assign count    = r_count;

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Scoreboard bench for fetch_inst_queue: stimulus pushes expected entries, a negedge monitor checks every pop.
module tb_fetch_inst_queue;
  localparam int DEPTH = 8;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [63:0] in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic [3:0]  count;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected entries derived from the beat format, not from the DUT.
  task automatic push_exp(input logic [63:0] pc, input logic [63:0] data);
    exp_t e;
    if (pc[2] == 1'b0) begin
      e.inst = data[31:0];  e.pc = {pc[63:2], 2'b00};        exp_q.push_back(e);
      e.inst = data[63:32]; e.pc = {pc[63:2], 2'b00} + 64'd4; exp_q.push_back(e);
    end else begin
      e.inst = data[63:32]; e.pc = {pc[63:3], 3'b100};        exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] pc, input logic [63:0] data);
    in_valid = 1'b1; in_pc = pc; in_data = data;
    push_exp(pc, data);
    step();
    in_valid = 1'b0;
  endtask

  // Monitor: a pop happens at the next edge whenever these conditions hold now.
  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop_pc", out_pc, 64'hX);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_inst", {32'h0, out_inst}, {32'h0, e.inst});
        chk("mon_pc", out_pc, e.pc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    step(); step();
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);
    step();

    // Aligned beat, lower half first
    out_ready = 1'b1;
    beat(64'h8000_0000, 64'h0000_0513_0010_0093);
    chk("t1_count2", 64'(count), 64'd2);
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    step();
    chk("t1_count1", 64'(count), 64'd1);
    step();
    chk("t1_count0", 64'(count), 64'd0);

    // Odd-word beat: single entry
    out_ready = 1'b0;
    beat(64'h8000_0004, 64'hAAAA_AAAA_BBBB_BBBB);
    chk("t2_count", 64'(count), 64'd1);
    chk("t2_inst", 64'(out_inst), 64'hAAAA_AAAA);
    chk("t2_pc", out_pc, 64'h8000_0004);
    out_ready = 1'b1;
    step();
    chk("t2_drained", 64'(count), 64'd0);

    // Fill to full, then free space one pop at a time
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_in_ready_fill", 64'(in_ready), 64'd1);
      beat(64'h1000 + 64'(i * 8), {32'hC000_0000 + 32'(2*i+1), 32'hC000_0000 + 32'(2*i)});
    end
    chk("t3_count_full", 64'(count), 64'd8);
    chk("t3_in_ready_full", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_pc = 64'h9000; in_data = 64'hDEAD_DEAD_DEAD_DEAD;
    step();
    in_valid = 1'b0;
    chk("t3_no_overflow", 64'(count), 64'd8);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t3_count7", 64'(count), 64'd7);
    chk("t3_in_ready7", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    step();
    chk("t3_count6", 64'(count), 64'd6);
    chk("t3_in_ready6", 64'(in_ready), 64'd1);
    step();
    out_ready = 1'b0;
    chk("t5_count5", 64'(count), 64'd5);

    // Flush beats a concurrent push and pop
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 64'h5000; in_data = 64'h5555_5555_6666_6666;
    flush = 1'b1;
    exp_q.delete();
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    step(); step();

    // Shift write pointer to 1, fill to 6, then push+pop straddling slots 7 and 0
    out_ready = 1'b0;
    beat(64'h2004, 64'h2222_2222_0000_0000);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t4_empty", 64'(count), 64'd0);
    beat(64'h3000, 64'h3000_0001_3000_0000);
    beat(64'h3008, 64'h3000_0003_3000_0002);
    beat(64'h3010, 64'h3000_0005_3000_0004);
    chk("t4_count6", 64'(count), 64'd6);
    out_ready = 1'b1;
    beat(64'h3018, 64'h3000_0007_3000_0006);
    chk("t4_count7", 64'(count), 64'd7);
    for (int i = 0; i < 7; i++) step();
    chk("t4_drained", 64'(count), 64'd0);

    // Top-of-address-space PCs, low PC bits ignored, zero instruction words
    out_ready = 1'b0;
    beat(64'hFFFF_FFFF_FFFF_FFF8, 64'h1111_1111_2222_2222);
    beat(64'hFFFF_FFFF_FFFF_FFFC, 64'h3333_3333_4444_4444);
    chk("t6_count3", 64'(count), 64'd3);
    beat(64'h4003, 64'h0000_0000_0000_0000);
    chk("t6_count5", 64'(count), 64'd5);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("t6_drained", 64'(count), 64'd0);

    // Reset mid-operation discards contents
    out_ready = 1'b0;
    beat(64'h6000, 64'h6666_0001_6666_0000);
    reset = 1'b1;
    exp_q.delete();
    step();
    chk("t7_reset_count", 64'(count), 64'd0);
    reset = 1'b0;
    #1;
    chk("t7_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step(); step();
    chk("final_out_valid", 64'(out_valid), 64'd0);
    chk("final_exp_left", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
